// File: rtl/cpu_pkg.sv
// Shared types and helpers for the CPU load/store path.
// Holds the access-size and FSM-state enums, the lane masks used when
// extracting and merging sub-word data, and the small alignment helpers
// that both the load/store unit and its lane aligner depend on.
package cpu_pkg;

  // Access width requested by the datapath; the encoding matches req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_t;

  // Load/store unit sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } mau_state_t;

  // Lane masks positioned at bit 0; they are shifted into place by the aligner.
  localparam logic [31:0] BYTE_LANE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_LANE_MASK = 32'h0000_FFFF;
  localparam logic [31:0] WORD_LANE_MASK = 32'hFFFF_FFFF;

  // True when the request cannot be served as a naturally aligned access.
  // The reserved size is always treated as misaligned.
  function automatic logic is_misaligned(input mem_size_t size,
                                         input logic [1:0] offset);
    logic result;
    case (size)
      SZ_BYTE: result = 1'b0;
      SZ_HALF: result = offset[0];
      SZ_WORD: result = (offset != 2'b00);
      default: result = 1'b1;
    endcase
    return result;
  endfunction

  // Rounds the byte offset down to the natural boundary of the access size.
  // When errors are flagged the result is never used for a misaligned access;
  // when force-alignment is selected this is what makes the access legal.
  function automatic logic [1:0] align_offset(input mem_size_t size,
                                              input logic [1:0] offset);
    logic [1:0] result;
    case (size)
      SZ_BYTE: result = offset;
      SZ_HALF: result = {offset[1], 1'b0};
      default: result = 2'b00;
    endcase
    return result;
  endfunction

  // The reserved size has no lane of its own; when it is allowed through
  // (force-align mode) it behaves as a full word access.
  function automatic mem_size_t effective_size(input mem_size_t size);
    mem_size_t result;
    if (size == SZ_RSVD) begin
      result = SZ_WORD;
    end else begin
      result = size;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purely combinational lane steering between a 32-bit RAM word and the
// byte/half/word view the datapath uses.
// The extract path pulls the addressed lane out of a word and zero- or
// sign-extends it; the merge path drops store data into the addressed
// lane(s) of an existing word while leaving every other byte untouched.
module mem_lane_align
  import cpu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic        is_signed,
  output logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] new_word
);

  logic [4:0]  shift;
  logic [31:0] lane_mask;
  logic [31:0] lane_bits;

  // Lane position: bit shift and unshifted mask for the addressed lane.
  // In big-endian order byte 0 sits in bits [31:24], so the lane index is
  // mirrored (3-offset for bytes, 2-offset for halves).
  always_comb begin
    shift     = 5'd0;
    lane_mask = WORD_LANE_MASK;
    case (size)
      SZ_BYTE: begin
        lane_mask = BYTE_LANE_MASK;
        if (BIG_ENDIAN) begin
          shift = {~offset, 3'b000};
        end else begin
          shift = {offset, 3'b000};
        end
      end
      SZ_HALF: begin
        lane_mask = HALF_LANE_MASK;
        if (BIG_ENDIAN) begin
          shift = {~offset[1], 4'b0000};
        end else begin
          shift = {offset[1], 4'b0000};
        end
      end
      default: begin
        lane_mask = WORD_LANE_MASK;
        shift     = 5'd0;
      end
    endcase
  end

  // Extract path: bring the lane down to bit 0, then extend it.
  // Word loads have no spare bits, so the signed flag does not matter there.
  always_comb begin
    lane_bits = (word >> shift) & lane_mask;
    rdata     = lane_bits;
    if (is_signed) begin
      case (size)
        SZ_BYTE: rdata = {{24{lane_bits[7]}}, lane_bits[7:0]};
        SZ_HALF: rdata = {{16{lane_bits[15]}}, lane_bits[15:0]};
        default: rdata = lane_bits;
      endcase
    end
  end

  // Merge path: clear the addressed lane(s) of the old word and insert the
  // low lane(s) of the store data there.
  always_comb begin
    new_word = (old_word & ~(lane_mask << shift)) | ((wdata & lane_mask) << shift);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end between the multicycle CPU datapath and the
// word-only unified RAM. One request is accepted at a time from IDLE.
// Loads read the aligned word and return the extracted lane; word stores
// write straight through; byte/half stores do a read-modify-write over two
// cycles. Misaligned or reserved-size requests either respond with an error
// without touching memory, or are forced down to alignment, depending on
// ERR_ON_MISALIGN. All state advances only on edges where clk_en is high.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter bit BIG_ENDIAN      = 1'b0,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  mau_state_t  state;

  logic        lat_we;
  mem_size_t   lat_size;
  logic        lat_signed;
  logic [1:0]  lat_offset;
  logic [31:0] lat_wdata;

  logic        wr_en_q;

  mem_size_t   in_size;
  mem_size_t   in_eff_size;
  logic        in_misalign;
  logic [1:0]  in_offset;
  logic        handshake;

  logic [31:0] load_data;
  logic [31:0] merged_word;

  // Decode of the incoming request, used only on the handshake edge.
  always_comb begin
    in_size     = mem_size_t'(req_size);
    in_eff_size = effective_size(in_size);
    in_misalign = is_misaligned(in_size, req_addr[1:0]);
    in_offset   = align_offset(in_size, req_addr[1:0]);
    handshake   = req_valid && req_ready;
  end

  // A reset edge must never commit a pending RMW write, so the registered
  // write enable is also masked by rst_n; the RAM sees it drop on the very
  // edge that reset is sampled.
  assign mem_wr_en = wr_en_q && rst_n;

  // Both the extract and merge paths look at the word currently read from
  // mem_addr, which holds the latched aligned address during ACCESS.
  mem_lane_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_align (
    .word      (mem_r_data),
    .offset    (lat_offset),
    .size      (lat_size),
    .is_signed (lat_signed),
    .rdata     (load_data),
    .old_word  (mem_r_data),
    .wdata     (lat_wdata),
    .new_word  (merged_word)
  );

  // Request sequencer: latches the request, drives the RAM interface and
  // produces the one-cycle response pulse. All outputs are registered here.
  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      wr_en_q    <= 1'b0;
      mem_addr   <= 32'd0;
      mem_w_data <= 32'd0;
      lat_we     <= 1'b0;
      lat_size   <= SZ_BYTE;
      lat_signed <= 1'b0;
      lat_offset <= 2'b00;
      lat_wdata  <= 32'd0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (handshake) begin
            lat_we     <= req_we;
            lat_size   <= in_eff_size;
            lat_signed <= req_signed;
            lat_offset <= in_offset;
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (in_misalign && ERR_ON_MISALIGN) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              state      <= RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_we && (in_eff_size == SZ_WORD)) begin
                wr_en_q    <= 1'b1;
                mem_w_data <= req_wdata;
              end
              state <= ACCESS;
            end
          end
        end

        ACCESS: begin
          if (!lat_we) begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (lat_size == SZ_WORD) begin
            wr_en_q    <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            mem_w_data <= merged_word;
            wr_en_q    <= 1'b1;
            state      <= WRITE;
          end
        end

        WRITE: begin
          wr_en_q    <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          wr_en_q    <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a small word RAM model.
// A table of directed requests is played in order against a RAM whose
// contents evolve; each entry carries hand-computed response data, error
// flag, latency in enabled edges, write count and resulting RAM word.
// Hand-written sequences cover the reset state, a clk_en-stalled half
// store and a reset that lands in the middle of a read-modify-write.
module tb_mem_access_unit;

  logic        clk_100M;
  logic        rst_n;
  logic        clk_en;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  logic [31:0] ram [0:63];
  int          write_count;
  int          checks;
  int          errors;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_writes;
    logic [31:0] exp_ram;
  } vec_t;

  vec_t vecs [16];

  mem_access_unit #(
    .BIG_ENDIAN      (1'b0),
    .ERR_ON_MISALIGN (1'b1)
  ) dut (
    .clk_100M   (clk_100M),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
  );

  // 100 MHz clock.
  initial begin
    clk_100M = 1'b0;
    forever #5 clk_100M = ~clk_100M;
  end

  // Word RAM: combinational read, write gated by clk_en like the real RAM.
  assign mem_r_data = ram[mem_addr[7:2]];

  always @(posedge clk_100M) begin
    if (clk_en && mem_wr_en) begin
      ram[mem_addr[7:2]] <= mem_w_data;
      write_count <= write_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Issues one request from IDLE and follows it to its response. Latency is
  // counted in enabled edges, the handshake edge being the first. With
  // toggle_en set, a disabled edge is inserted before every enabled one.
  task automatic apply_stimulus(input logic we, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit toggle_en,
                                output int lat, output logic [31:0] rdata,
                                output logic err, output logic timeout,
                                output int writes);
    int start_writes;
    start_writes = write_count;
    clk_en     = 1'b1;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid = 1'b0;
    lat       = 1;
    for (int i = 0; i < 40 && !resp_valid; i++) begin
      if (toggle_en) begin
        clk_en = 1'b0;
        tick();
        clk_en = 1'b1;
      end
      tick();
      lat++;
    end
    timeout = !resp_valid;
    rdata   = resp_rdata;
    err     = resp_err;
    tick();
    writes = write_count - start_writes;
  endtask

  initial begin
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
    int          writes;
    int          start_writes;

    checks      = 0;
    errors      = 0;
    write_count = 0;
    for (int i = 0; i < 64; i++) ram[i] = 32'd0;
    ram[4] = 32'hDEAD_BEEF;

    //            we    size   sgn   addr        wdata         rdata         err   lat wr  ram word
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hDEADBEEF, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         32'hFFFFFFDE, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'h000000DE, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         32'hFFFFBEEF, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'h0000DEAD, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0,         32'hFFFFFFEF, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h55,        32'h00000000, 1'b0, 3, 1, 32'hDEAD55EF};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h12, 32'h11223344,  32'h00000000, 1'b1, 1, 0, 32'hDEAD55EF};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0,         32'h00000000, 1'b1, 1, 0, 32'hDEAD55EF};
    vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         32'h00000000, 1'b1, 1, 0, 32'hDEAD55EF};
    vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678,  32'h00000000, 1'b0, 2, 1, 32'h12345678};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFFABCD,  32'h00000000, 1'b0, 3, 1, 32'hABCD5678};
    vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h21, 32'h0,         32'h00000056, 1'b0, 2, 0, 32'hABCD5678};
    vecs[13] = '{1'b0, 2'b00, 1'b0, 32'h23, 32'h0,         32'h000000AB, 1'b0, 2, 0, 32'hABCD5678};
    vecs[14] = '{1'b1, 2'b00, 1'b0, 32'h22, 32'h123456FF,  32'h00000000, 1'b0, 3, 1, 32'hABFF5678};
    vecs[15] = '{1'b0, 2'b10, 1'b1, 32'h20, 32'h0,         32'hABFF5678, 1'b0, 2, 0, 32'hABFF5678};

    rst_n      = 1'b0;
    clk_en     = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    tick();
    tick();

    // Reset state, with clk_en low to show reset does not need it.
    check_output("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_output("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_output("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check_output("rst_resp_rdata", resp_rdata, 32'd0);
    check_output("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'd0);
    check_output("rst_mem_w_data", mem_w_data, 32'd0);
    rst_n  = 1'b1;
    clk_en = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                     vecs[i].wdata, 1'b0, lat, rdata, err, timeout, writes);
      check_output($sformatf("v%0d_timeout", i), {31'd0, timeout}, 32'd0);
      check_output($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check_output($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check_output($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check_output($sformatf("v%0d_writes", i), 32'(writes), 32'(vecs[i].exp_writes));
      check_output($sformatf("v%0d_ram", i), ram[vecs[i].addr[7:2]], vecs[i].exp_ram);
      check_output($sformatf("v%0d_ready_after", i), {31'd0, req_ready}, 32'd1);
    end

    // Half store with clk_en toggling every cycle; latency in enabled edges.
    ram[4] = 32'hDEAD_BEEF;
    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000A5A5, 1'b1,
                   lat, rdata, err, timeout, writes);
    check_output("stall_timeout", {31'd0, timeout}, 32'd0);
    check_output("stall_latency", 32'(lat), 32'd3);
    check_output("stall_writes", 32'(writes), 32'd1);
    check_output("stall_ram", ram[4], 32'hA5A5BEEF);
    check_output("stall_err", {31'd0, err}, 32'd0);

    // Reset landing in WRITE of a byte RMW: the write must be dropped.
    clk_en     = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h21;
    req_wdata  = 32'h77;
    start_writes = write_count;
    tick();
    req_valid = 1'b0;
    check_output("rmw_access_addr", mem_addr, 32'h20);
    check_output("rmw_access_wr_en", {31'd0, mem_wr_en}, 32'd0);
    tick();
    check_output("rmw_write_wr_en", {31'd0, mem_wr_en}, 32'd1);
    check_output("rmw_write_data", mem_w_data, 32'hABFF7778);
    rst_n = 1'b0;
    tick();
    check_output("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    check_output("rmw_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_output("rmw_rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check_output("rmw_rst_ram", ram[8], 32'hABFF5678);
    check_output("rmw_rst_writes", 32'(write_count - start_writes), 32'd0);
    check_output("rmw_rst_no_resp", {31'd0, resp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
